// File: rtl/axi_noc_vc_slave.sv
// AXI4 slave (no IDs, INCR) bridging PE writes to the packet generator and PE reads
// to per-VC RX FIFOs, with read-only per-VC occupancy CSRs and SLVERR on bad accesses.
module axi_noc_vc_slave #(
   parameter int N_VC = 3,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16,
   parameter int RX_DEPTH = 4,
   parameter logic [ADDR_W-1:0] WR_BASE = 'h1000,
   parameter logic [ADDR_W-1:0] RD_BASE = 'h2000,
   parameter logic [ADDR_W-1:0] CSR_BASE = 'h3000,
   localparam int VCW = (N_VC > 1) ? $clog2(N_VC) : 1
) (
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              awvalid_i,
   output logic              awready_o,
   input  logic [ADDR_W-1:0] awaddr_i,
   input  logic [7:0]        awlen_i,
   input  logic              wvalid_i,
   output logic              wready_o,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              wlast_i,
   output logic              bvalid_o,
   input  logic              bready_i,
   output logic [1:0]        bresp_o,
   input  logic              arvalid_i,
   output logic              arready_o,
   input  logic [ADDR_W-1:0] araddr_i,
   input  logic [7:0]        arlen_i,
   output logic              rvalid_o,
   input  logic              rready_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic [1:0]        rresp_o,
   output logic              rlast_o,
   output logic              tx_valid_o,
   input  logic              tx_ready_i,
   output logic [VCW-1:0]    tx_vc_o,
   output logic [DATA_W-1:0] tx_data_o,
   output logic              tx_head_o,
   output logic              tx_tail_o,
   output logic [8:0]        tx_pkt_sz_o,
   input  logic              rx_valid_i,
   output logic              rx_ready_o,
   input  logic [VCW-1:0]    rx_vc_i,
   input  logic [DATA_W-1:0] rx_data_i
);
   // state | meaning
   // W_IDLE | waiting for AW
   // W_DATA | accepting W beats (forwarded to TX on a hit, dropped otherwise)
   // W_RESP | presenting B
   // R_IDLE | waiting for AR
   // R_DATA | presenting R beats until the rlast handshake
   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   localparam logic [1:0] REG_MISS = 2'd0;
   localparam logic [1:0] REG_TX = 2'd1;
   localparam logic [1:0] REG_RX = 2'd2;
   localparam logic [1:0] REG_CSR = 2'd3;
   localparam logic [1:0] OKAY = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   localparam int OCC_W = $clog2(RX_DEPTH + 1);
   localparam int PTR_W = $clog2(RX_DEPTH);
   localparam logic [ADDR_W-1:0] NVC_A = ADDR_W'(N_VC);
   localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(RX_DEPTH);

   // Each VC owns an 8-byte slot inside each of the three windows.
   function automatic logic [VCW+1:0] decode(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] ow, orr, oc;
      logic [VCW+1:0] res;
      ow = a - WR_BASE;
      orr = a - RD_BASE;
      oc = a - CSR_BASE;
      res = {REG_MISS, {VCW{1'b0}}};
      if (a >= WR_BASE && (ow >> 3) < NVC_A) res = {REG_TX, ow[VCW+2:3]};
      else if (a >= RD_BASE && (orr >> 3) < NVC_A) res = {REG_RX, orr[VCW+2:3]};
      else if (a >= CSR_BASE && (oc >> 3) < NVC_A) res = {REG_CSR, oc[VCW+2:3]};
      return res;
   endfunction

   logic              live_q;
   logic [1:0]        w_state_q, w_state_d;
   logic [7:0]        w_len_q, w_len_d;
   logic [VCW-1:0]    w_vc_q, w_vc_d;
   logic              w_hit_q, w_hit_d;
   logic              w_err_q, w_err_d;
   logic [8:0]        w_beat_q, w_beat_d;
   logic [1:0]        bresp_q, bresp_d;
   logic              w_mis;
   logic [VCW+1:0]    aw_dec, ar_dec;

   logic [0:0]        r_state_q, r_state_d;
   logic [7:0]        r_len_q, r_len_d;
   logic [7:0]        r_beat_q, r_beat_d;
   logic [VCW-1:0]    r_vc_q, r_vc_d;
   logic [1:0]        r_reg_q, r_reg_d;
   logic [OCC_W-1:0]  csr_q, csr_d;

   logic [DATA_W-1:0] mem_q [N_VC][RX_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q [N_VC];
   logic [PTR_W-1:0]  rd_ptr_q [N_VC];
   logic [OCC_W-1:0]  cnt_q [N_VC];
   logic [N_VC-1:0]   push_vec, pop_vec;
   logic              push, pop, rx_vc_ok;

   assign aw_dec = decode(awaddr_i);
   assign ar_dec = decode(araddr_i);

   always_comb begin
      w_state_d = w_state_q;
      w_len_d = w_len_q;
      w_vc_d = w_vc_q;
      w_hit_d = w_hit_q;
      w_err_d = w_err_q;
      w_beat_d = w_beat_q;
      bresp_d = bresp_q;
      awready_o = live_q && (w_state_q == W_IDLE);
      wready_o = 1'b0;
      tx_valid_o = 1'b0;
      tx_vc_o = '0;
      tx_data_o = '0;
      tx_head_o = 1'b0;
      tx_tail_o = 1'b0;
      tx_pkt_sz_o = '0;
      bvalid_o = (w_state_q == W_RESP);
      bresp_o = bresp_q;
      // A length error is any beat where wlast disagrees with "this is beat awlen".
      w_mis = wlast_i != (w_beat_q == {1'b0, w_len_q});
      case (w_state_q)
         W_IDLE: begin
            if (awvalid_i && awready_o) begin
               w_state_d = W_DATA;
               w_len_d = awlen_i;
               w_vc_d = aw_dec[VCW-1:0];
               w_hit_d = (aw_dec[VCW+1:VCW] == REG_TX);
               w_err_d = (aw_dec[VCW+1:VCW] != REG_TX);
               w_beat_d = '0;
            end
         end
         W_DATA: begin
            if (w_hit_q) begin
               tx_valid_o = wvalid_i;
               wready_o = tx_ready_i;
               tx_vc_o = w_vc_q;
               tx_data_o = wdata_i;
               tx_head_o = (w_beat_q == '0);
               tx_tail_o = wlast_i;
               tx_pkt_sz_o = {1'b0, w_len_q} + 9'd1;
            end else begin
               wready_o = 1'b1;
            end
            if (wvalid_i && wready_o) begin
               if (~&w_beat_q) w_beat_d = w_beat_q + 9'd1;
               if (w_mis) w_err_d = 1'b1;
               if (wlast_i) begin
                  w_state_d = W_RESP;
                  bresp_d = (w_err_q || w_mis) ? SLVERR : OKAY;
               end
            end
         end
         W_RESP: begin
            if (bready_i) begin
               w_state_d = W_IDLE;
               bresp_d = OKAY;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      r_len_d = r_len_q;
      r_beat_d = r_beat_q;
      r_vc_d = r_vc_q;
      r_reg_d = r_reg_q;
      csr_d = csr_q;
      arready_o = live_q && (r_state_q == R_IDLE);
      rvalid_o = 1'b0;
      rdata_o = '0;
      rresp_o = OKAY;
      rlast_o = 1'b0;
      if (r_state_q == R_IDLE) begin
         if (arvalid_i && arready_o) begin
            r_state_d = R_DATA;
            r_len_d = arlen_i;
            r_beat_d = '0;
            r_vc_d = ar_dec[VCW-1:0];
            r_reg_d = ar_dec[VCW+1:VCW];
            csr_d = cnt_q[ar_dec[VCW-1:0]];
         end
      end else begin
         rlast_o = (r_beat_q == r_len_q);
         case (r_reg_q)
            REG_RX: begin
               rvalid_o = (cnt_q[r_vc_q] != '0);
               rdata_o = mem_q[r_vc_q][rd_ptr_q[r_vc_q]];
            end
            // Occupancy is captured once per beat so it cannot change under a stalled beat.
            REG_CSR: begin
               rvalid_o = 1'b1;
               rdata_o = DATA_W'(csr_q);
            end
            default: begin
               rvalid_o = 1'b1;
               rresp_o = SLVERR;
            end
         endcase
         if (rvalid_o && rready_i) begin
            if (rlast_o) begin
               r_state_d = R_IDLE;
            end else begin
               r_beat_d = r_beat_q + 8'd1;
               csr_d = cnt_q[r_vc_q];
            end
         end
      end
   end

   assign rx_vc_ok = {1'b0, rx_vc_i} < (VCW+1)'(N_VC);
   assign rx_ready_o = live_q && rx_vc_ok && (cnt_q[rx_vc_i] != FULL_CNT);
   assign push = rx_valid_i && rx_ready_o;
   assign pop = (r_state_q == R_DATA) && (r_reg_q == REG_RX) && rvalid_o && rready_i;

   always_comb begin
      push_vec = '0;
      pop_vec = '0;
      for (int v = 0; v < N_VC; v++) begin
         push_vec[v] = push && (rx_vc_i == VCW'(v));
         pop_vec[v] = pop && (r_vc_q == VCW'(v));
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         live_q <= 1'b0;
         w_state_q <= W_IDLE;
         w_len_q <= '0;
         w_vc_q <= '0;
         w_hit_q <= 1'b0;
         w_err_q <= 1'b0;
         w_beat_q <= '0;
         bresp_q <= OKAY;
         r_state_q <= R_IDLE;
         r_len_q <= '0;
         r_beat_q <= '0;
         r_vc_q <= '0;
         r_reg_q <= REG_MISS;
         csr_q <= '0;
         for (int v = 0; v < N_VC; v++) begin
            wr_ptr_q[v] <= '0;
            rd_ptr_q[v] <= '0;
            cnt_q[v] <= '0;
         end
      end else begin
         live_q <= 1'b1;
         w_state_q <= w_state_d;
         w_len_q <= w_len_d;
         w_vc_q <= w_vc_d;
         w_hit_q <= w_hit_d;
         w_err_q <= w_err_d;
         w_beat_q <= w_beat_d;
         bresp_q <= bresp_d;
         r_state_q <= r_state_d;
         r_len_q <= r_len_d;
         r_beat_q <= r_beat_d;
         r_vc_q <= r_vc_d;
         r_reg_q <= r_reg_d;
         csr_q <= csr_d;
         for (int v = 0; v < N_VC; v++) begin
            if (push_vec[v]) wr_ptr_q[v] <= wr_ptr_q[v] + PTR_W'(1);
            if (pop_vec[v]) rd_ptr_q[v] <= rd_ptr_q[v] + PTR_W'(1);
            if (push_vec[v] && !pop_vec[v]) cnt_q[v] <= cnt_q[v] + OCC_W'(1);
            else if (!push_vec[v] && pop_vec[v]) cnt_q[v] <= cnt_q[v] - OCC_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[rx_vc_i][wr_ptr_q[rx_vc_i]] <= rx_data_i;
   end

endmodule

// File: tb/tb_axi_noc_vc_slave.sv
// Scoreboard bench for axi_noc_vc_slave: stimulus tasks queue expectations, a negedge
// monitor checks TX flits, B/R responses and RX flow control against a queue-based model.
module tb_axi_noc_vc_slave;
   logic clk = 1'b0;
   logic arst = 1'b1;
   logic awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
   logic tx_ready = 0, rx_valid = 0;
   logic [15:0] awaddr = 0, araddr = 0;
   logic [7:0] awlen = 0, arlen = 0;
   logic [31:0] wdata = 0, rx_data = 0;
   logic [1:0] rx_vc = 0;
   logic awready, wready, bvalid, arready, rvalid, rlast, tx_valid, tx_head, tx_tail, rx_ready;
   logic [1:0] bresp, rresp, tx_vc;
   logic [31:0] rdata, tx_data;
   logic [8:0] tx_pkt_sz;

   axi_noc_vc_slave dut (
      .clk_i(clk), .arst_i(arst),
      .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr), .awlen_i(awlen),
      .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wlast_i(wlast),
      .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp),
      .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr), .arlen_i(arlen),
      .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
      .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_vc_o(tx_vc), .tx_data_o(tx_data),
      .tx_head_o(tx_head), .tx_tail_o(tx_tail), .tx_pkt_sz_o(tx_pkt_sz),
      .rx_valid_i(rx_valid), .rx_ready_o(rx_ready), .rx_vc_i(rx_vc), .rx_data_i(rx_data)
   );

   always #5 clk = ~clk;

   localparam int R_MISS = 0, R_TX = 1, R_RX = 2, R_CSR = 3;
   localparam int DEPTH = 4;

   typedef struct {logic [1:0] vc; logic [31:0] data; logic head; logic tail; logic [8:0] sz;} flit_t;
   typedef struct {int region; int vc; int len;} rd_t;

   flit_t tx_exp[$];
   logic [1:0] b_exp[$];
   rd_t rd_pend[$];
   bit wr_pend[$];
   logic [31:0] fifo_m[3][$];

   int checks = 0, errors = 0;
   bit rd_act = 0, wr_act = 0, wr_hit = 0, up = 0;
   rd_t rd_cur;
   int rd_beat = 0;
   int csr_samp = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s at %0t", nm, $time);
   endtask

   function automatic int region_of(input logic [15:0] a, output int vc);
      int ai;
      ai = int'(a);
      vc = 0;
      if (ai >= 'h1000 && ai < 'h1018) begin vc = (ai - 'h1000) / 8; return R_TX; end
      if (ai >= 'h2000 && ai < 'h2018) begin vc = (ai - 'h2000) / 8; return R_RX; end
      if (ai >= 'h3000 && ai < 'h3018) begin vc = (ai - 'h3000) / 8; return R_CSR; end
      return R_MISS;
   endfunction

   // Monitor / scoreboard
   always @(negedge clk) begin
      bit push_ok;
      logic [31:0] ed;
      logic [1:0] er;
      bit last;
      flit_t f;
      if (arst) begin
         check("rst_ctrl", {awready, wready, bvalid, arready, rvalid, tx_valid, rx_ready, rlast}, 0);
         check("rst_data", {rdata, rresp, bresp}, 0);
         tx_exp.delete(); b_exp.delete(); rd_pend.delete(); wr_pend.delete();
         for (int v = 0; v < 3; v++) fifo_m[v].delete();
         rd_act = 0; wr_act = 0; up = 0;
      end else begin
         if (up && rx_valid) check("rx_ready", rx_ready, fifo_m[rx_vc].size() < DEPTH);
         push_ok = rx_valid && rx_ready;
         if (rd_act) check("rvalid", rvalid, (rd_cur.region == R_RX) ? (fifo_m[rd_cur.vc].size() != 0) : 1'b1);
         else check("rvalid_idle", rvalid, 0);
         if (rd_act && rvalid && rready) begin
            last = (rd_beat == rd_cur.len);
            ed = 0; er = 2'b10;
            if (rd_cur.region == R_RX) begin ed = fifo_m[rd_cur.vc].pop_front(); er = 0; end
            else if (rd_cur.region == R_CSR) begin ed = csr_samp; er = 0; end
            check("rdata", rdata, ed);
            check("rresp", rresp, er);
            check("rlast", rlast, last);
            rd_beat++;
            if (rd_cur.region == R_CSR) csr_samp = fifo_m[rd_cur.vc].size();
            if (last) rd_act = 0;
         end else if (!rd_act && arvalid && arready) begin
            if (rd_pend.size() == 0) fail("ar_unexpected");
            else begin
               rd_cur = rd_pend.pop_front();
               rd_act = 1; rd_beat = 0;
               csr_samp = fifo_m[rd_cur.vc].size();
            end
         end
         check("tx_valid", tx_valid, wr_act && wr_hit && wvalid);
         if (wr_act && wvalid) check("wready", wready, wr_hit ? tx_ready : 1'b1);
         if (tx_valid && tx_ready) begin
            if (tx_exp.size() == 0) fail("tx_unexpected");
            else begin
               f = tx_exp.pop_front();
               check("tx_vc", tx_vc, f.vc);
               check("tx_data", tx_data, f.data);
               check("tx_head_tail", {tx_head, tx_tail}, {f.head, f.tail});
               check("tx_pkt_sz", tx_pkt_sz, f.sz);
            end
         end
         if (wr_act && wvalid && wready && wlast) wr_act = 0;
         else if (!wr_act && awvalid && awready) begin
            if (wr_pend.size() == 0) fail("aw_unexpected");
            else begin wr_hit = wr_pend.pop_front(); wr_act = 1; end
         end
         if (bvalid && bready) begin
            if (b_exp.size() == 0) fail("b_unexpected");
            else check("bresp", bresp, b_exp.pop_front());
         end
         if (push_ok) fifo_m[rx_vc].push_back(rx_data);
         up = 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic aw_hs(input logic [15:0] a, input int len);
      bit got;
      int n;
      awvalid = 1; awaddr = a; awlen = 8'(len);
      n = 0;
      do begin @(negedge clk); got = awready; tick(); n++; end while (!got && n < 50);
      awvalid = 0;
      if (!got) fail("aw_timeout");
   endtask

   task automatic ar_hs(input logic [15:0] a, input int len);
      bit got;
      int n;
      arvalid = 1; araddr = a; arlen = 8'(len);
      n = 0;
      do begin @(negedge clk); got = arready; tick(); n++; end while (!got && n < 50);
      arvalid = 0;
      if (!got) fail("ar_timeout");
   endtask

   // mode 0: tx_ready held 1, 1: toggles 1/0, 2: random
   task automatic wr_burst(input logic [15:0] a, input int len, input int nbeats, input int mode);
      int reg_, vc, n, dly;
      bit got, tg;
      logic [31:0] d[16];
      flit_t f;
      reg_ = region_of(a, vc);
      for (int i = 0; i < nbeats; i++) d[i] = $urandom;
      wr_pend.push_back(reg_ == R_TX);
      if (reg_ == R_TX)
         for (int i = 0; i < nbeats; i++) begin
            f.vc = 2'(vc); f.data = d[i]; f.head = (i == 0); f.tail = (i == nbeats - 1); f.sz = 9'(len + 1);
            tx_exp.push_back(f);
         end
      b_exp.push_back((reg_ == R_TX && nbeats == len + 1) ? 2'b00 : 2'b10);
      aw_hs(a, len);
      tg = 1;
      for (int i = 0; i < nbeats; i++) begin
         wvalid = 1; wdata = d[i]; wlast = (i == nbeats - 1);
         n = 0;
         do begin
            tx_ready = (mode == 0) ? 1'b1 : (mode == 1) ? tg : 1'($urandom_range(0, 1));
            tg = ~tg;
            @(negedge clk); got = wready; tick(); n++;
         end while (!got && n < 50);
         if (!got) fail("w_timeout");
      end
      wvalid = 0; wlast = 0; tx_ready = 0;
      dly = $urandom_range(0, 2);
      repeat (dly) tick();
      bready = 1;
      n = 0;
      do begin @(negedge clk); got = bvalid; tick(); n++; end while (!got && n < 50);
      bready = 0;
      if (!got) fail("b_timeout");
   endtask

   task automatic rd_burst(input logic [15:0] a, input int len, input bit rnd);
      rd_t r;
      int got, n;
      r.region = region_of(a, r.vc);
      r.len = len;
      rd_pend.push_back(r);
      ar_hs(a, len);
      got = 0; n = 0;
      while (got <= len && n < 200) begin
         rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (rvalid && rready) got++;
         tick();
         n++;
      end
      rready = 0;
      if (got <= len) fail("r_timeout");
   endtask

   task automatic rx_push(input int vc, input logic [31:0] d);
      bit got;
      int n;
      rx_valid = 1; rx_vc = 2'(vc); rx_data = d;
      n = 0;
      do begin @(negedge clk); got = rx_ready; tick(); n++; end while (!got && n < 20);
      rx_valid = 0;
      if (!got) fail("rx_timeout");
   endtask

   task automatic rx_try(input int vc, input logic [31:0] d);
      rx_valid = 1; rx_vc = 2'(vc); rx_data = d;
      @(negedge clk);
      tick();
      rx_valid = 0;
   endtask

   initial begin
      logic [15:0] addrs[12];
      int op, len, nb, vc, sz;
      addrs = '{16'h1000, 16'h1008, 16'h1010, 16'h1004, 16'h1018, 16'h2000,
                16'h2008, 16'h2010, 16'h3000, 16'h3008, 16'h3010, 16'h5000};
      repeat (3) @(posedge clk);
      #1 arst = 0;
      repeat (2) tick();

      wr_burst(16'h1008, 3, 4, 0);
      wr_burst(16'h1008, 3, 4, 1);

      for (int i = 0; i < 4; i++) rx_push(0, 32'hA000_0000 + i);
      rx_try(0, 32'hDEAD_BEEF);
      rd_burst(16'h3000, 0, 0);
      rd_burst(16'h2000, 3, 0);

      fork
         rd_burst(16'h2008, 1, 0);
         begin
            repeat (6) tick();
            rx_push(1, 32'h1111_0001);
            repeat (6) tick();
            rx_push(1, 32'h1111_0002);
         end
      join

      wr_burst(16'h2000, 0, 1, 0);
      rd_burst(16'h5000, 2, 1);
      wr_burst(16'h1000, 2, 2, 0);
      wr_burst(16'h1010, 1, 3, 2);

      // Abort a write and a stalled read with reset.
      rx_push(2, 32'h2222_0001);
      rx_push(2, 32'h2222_0002);
      begin
         rd_t r;
         r.region = R_RX; r.vc = 2; r.len = 3;
         rd_pend.push_back(r);
      end
      ar_hs(16'h2010, 3);
      wr_pend.push_back(1'b1);
      begin
         flit_t f;
         f.vc = 0; f.data = 32'hCAFE_0000; f.head = 1; f.tail = 0; f.sz = 9'd4;
         tx_exp.push_back(f);
      end
      b_exp.push_back(2'b00);
      aw_hs(16'h1000, 3);
      wvalid = 1; wdata = 32'hCAFE_0000; wlast = 0; tx_ready = 1;
      @(negedge clk);
      tick();
      wvalid = 0; tx_ready = 0;
      tick();
      arst = 1;
      repeat (2) tick();
      arst = 0;
      repeat (2) tick();
      rd_burst(16'h3010, 0, 0);
      wr_burst(16'h1010, 2, 3, 0);
      rx_push(2, 32'h3333_0001);
      rd_burst(16'h2010, 0, 0);

      for (int it = 0; it < 30; it++) begin
         op = $urandom_range(0, 2);
         if (op == 0) begin
            len = $urandom_range(0, 4);
            nb = len + 1;
            if ($urandom_range(0, 4) == 0) nb = (len > 0 && $urandom_range(0, 1) == 1) ? len : len + 2;
            wr_burst(addrs[$urandom_range(0, 11)], len, nb, $urandom_range(0, 2));
         end else if (op == 1) begin
            vc = $urandom_range(0, 2);
            for (int k = $urandom_range(1, 3); k > 0; k--) begin
               if (fifo_m[vc].size() < DEPTH) rx_push(vc, $urandom);
               else rx_try(vc, $urandom);
            end
         end else begin
            vc = $urandom_range(0, 2);
            sz = fifo_m[vc].size();
            case ($urandom_range(0, 2))
               0: if (sz > 0) rd_burst(16'(16'h2000 + 8 * vc), $urandom_range(0, sz - 1), 1'($urandom_range(0, 1)));
                  else rd_burst(16'(16'h3000 + 8 * vc), 1, 1);
               1: rd_burst(16'(16'h3000 + 8 * vc), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
               default: rd_burst(16'(16'h1000 + 8 * vc), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            endcase
         end
      end

      repeat (3) tick();
      if (tx_exp.size() != 0) fail("tx_flits_missing");
      if (b_exp.size() != 0) fail("b_missing");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end
endmodule
